// File: rtl/dfc_pkg.sv
// Shared constants and configuration checks for the DFC receive path.
package dfc_pkg;

   // Words the sender can still deliver after c_fc_n falls:
   // c_fc_n flop, two fc delay stages, sender register, two data stages.
   localparam int unsigned DFC_RT_SLACK = 5;

   function automatic bit dfc_is_pow2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   // Hard legality: power-of-two depth and a threshold that can be reached.
   function automatic bit dfc_cfg_legal(input int unsigned depth, input int unsigned threshold);
      return dfc_is_pow2(depth) && (threshold < depth);
   endfunction

   // Depth must absorb the in-flight words after credit is withdrawn.
   function automatic bit dfc_cfg_slack_ok(input int unsigned depth, input int unsigned threshold);
      return depth >= (threshold + 1 + DFC_RT_SLACK);
   endfunction

endpackage

// File: rtl/dfc_rx_mem.sv
// Receive FIFO storage: depth x width, one write port, asynchronous read, no reset.
module dfc_rx_mem
   import dfc_pkg::*;
#(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 8
)(
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(depth)-1:0]   waddr,
   input  logic [width-1:0]           wdata,
   input  logic [$clog2(depth)-1:0]   raddr,
   output logic [width-1:0]           rdata
);

   logic [width-1:0] mem_q [depth];

   // Store the incoming word at the write address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Head-of-FIFO word is read combinationally from the registered array.
   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/dfc_rx_fifo.sv
// Credit-based link receive FIFO: stores link words, presents them on a
// srdy/drdy port and returns registered flow control to the sender.
module dfc_rx_fifo
   import dfc_pkg::*;
#(
   parameter int unsigned width     = 8,
   parameter int unsigned depth     = 8,
   parameter int unsigned threshold = 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             c_vld,
   input  logic [width-1:0] c_data,
   output logic             c_fc_n,
   output logic             p_srdy,
   output logic [width-1:0] p_data,
   input  logic             p_drdy
);

   localparam int unsigned asz = $clog2(depth);
   localparam logic [asz:0] THRESH_CMP = (asz + 1)'(threshold);

   if (!dfc_cfg_legal(depth, threshold)) begin : g_cfg_illegal
      $error("dfc_rx_fifo: depth must be a power of two >= 2 and threshold < depth");
   end

   if (!dfc_cfg_slack_ok(depth, threshold)) begin : g_cfg_slack
      $warning("dfc_rx_fifo: depth cannot absorb the link round trip above threshold");
   end

   logic [asz:0] wr_ptr_q, wr_ptr_d;
   logic [asz:0] rd_ptr_q, rd_ptr_d;
   logic [asz:0] usage_d;
   logic         c_fc_n_q, c_fc_n_d;
   logic         empty, full, wr_en, rd_en;

   // Pointer, occupancy and credit next-state; a write on a full FIFO is
   // only accepted when a read frees the slot in the same cycle.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[asz] != rd_ptr_q[asz]) &&
                 (wr_ptr_q[asz-1:0] == rd_ptr_q[asz-1:0]);
      rd_en    = !empty && p_drdy;
      wr_en    = c_vld && (!full || rd_en);
      wr_ptr_d = wr_ptr_q + {{asz{1'b0}}, wr_en};
      rd_ptr_d = rd_ptr_q + {{asz{1'b0}}, rd_en};
      usage_d  = wr_ptr_d - rd_ptr_d;
      c_fc_n_d = (usage_d <= THRESH_CMP);
   end

   // State registers; reset empties the FIFO and grants credit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         c_fc_n_q <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         c_fc_n_q <= c_fc_n_d;
      end
   end

   dfc_rx_mem #(
      .width (width),
      .depth (depth)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q[asz-1:0]),
      .wdata (c_data),
      .raddr (rd_ptr_q[asz-1:0]),
      .rdata (p_data)
   );

   // Outputs derive only from registered state.
   always_comb begin
      p_srdy = !empty;
      c_fc_n = c_fc_n_q;
   end

endmodule

// File: tb/tb_dfc_rx_fifo.sv
// Directed testbench for dfc_rx_fifo with a credit sender link model.
module tb_dfc_rx_fifo;

   localparam int W = 8;
   localparam int D = 8;
   localparam int T = 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         c_vld;
   logic [W-1:0] c_data;
   logic         c_fc_n;
   logic         p_srdy;
   logic [W-1:0] p_data;
   logic         p_drdy;

   dfc_rx_fifo #(
      .width     (W),
      .depth     (D),
      .threshold (T)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .c_vld  (c_vld),
      .c_data (c_data),
      .c_fc_n (c_fc_n),
      .p_srdy (p_srdy),
      .p_data (p_data),
      .p_drdy (p_drdy)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // link model: sender register, two data stages, two fc return stages
   logic         fc1, fc2, s_vld, d1_vld;
   logic [W-1:0] s_data, d1_data, s_seq, exp_seq, first_rd;
   logic         first_seen;
   logic [31:0]  src_pat, snk_pat;
   int           src_len, snk_len, src_idx, snk_idx;

   // occupancy model and observations
   int   m_usage, peak, ok_cnt, data_err, srdy_err, fc_err, ovf_cnt, uflow_cnt, fc_low;
   logic m_fc;

   task automatic clear_stats();
      peak = 0; ok_cnt = 0; data_err = 0; srdy_err = 0; fc_err = 0;
      ovf_cnt = 0; uflow_cnt = 0; fc_low = 0; first_seen = 1'b0; first_rd = '0;
   endtask

   task automatic clear_link();
      fc1 = 1'b1; fc2 = 1'b1; s_vld = 1'b0; d1_vld = 1'b0;
      s_data = '0; d1_data = '0; c_vld = 1'b0; c_data = '0; p_drdy = 1'b0;
      m_usage = 0; m_fc = 1'b1;
   endtask

   // Ends on a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      clear_link();
      s_seq = '0; exp_seq = '0;
      clear_stats();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock of link traffic, evaluated on the falling edge.
   task automatic link_cycle();
      logic rd, rd_m, wr_ok;
      if (p_srdy !== (m_usage != 0)) srdy_err++;
      if (c_fc_n !== m_fc) fc_err++;
      c_vld   = d1_vld;  c_data  = d1_data;
      d1_vld  = s_vld;   d1_data = s_data;
      s_vld   = src_pat[src_idx] && fc2;
      s_data  = s_seq;
      if (s_vld) s_seq++;
      fc2     = fc1;     fc1     = c_fc_n;
      p_drdy  = snk_pat[snk_idx];
      src_idx = (src_idx + 1) % src_len;
      snk_idx = (snk_idx + 1) % snk_len;
      rd = p_srdy && p_drdy;
      if (rd) begin
         if (!first_seen) begin first_rd = p_data; first_seen = 1'b1; end
         if (p_data === exp_seq) begin ok_cnt++; exp_seq++; end
         else begin data_err++; exp_seq = p_data + 8'd1; end
      end
      rd_m = rd && (m_usage > 0);
      if (rd && m_usage == 0) uflow_cnt++;
      wr_ok = c_vld && ((m_usage < D) || rd_m);
      if (c_vld && !wr_ok) ovf_cnt++;
      m_usage = m_usage + (wr_ok ? 1 : 0) - (rd_m ? 1 : 0);
      m_fc = (m_usage <= T);
      if (!m_fc) fc_low++;
      if (m_usage > peak) peak = m_usage;
      @(negedge clk);
   endtask

   task automatic run_traffic(input logic [31:0] sp, input int sl, input logic [31:0] kp,
                              input int kl, input int ncyc, input int stop_ok);
      src_pat = sp; src_len = sl; snk_pat = kp; snk_len = kl;
      src_idx = 0; snk_idx = 0;
      for (int i = 0; i < ncyc; i++) begin
         link_cycle();
         if (stop_ok > 0 && ok_cnt >= stop_ok) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; c_vld = 1'b0; c_data = '0; p_drdy = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk_cnt++;
      if (p_srdy !== 1'b0) $display("FAIL reset_srdy: got %b want 0", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b1) $display("FAIL reset_fc: got %b want 1", c_fc_n); else pass_cnt++;
      c_vld = 1'b1; c_data = 8'h77;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if (p_srdy !== 1'b0) $display("FAIL reset_vld_ignored: p_srdy got %b want 0", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b1) $display("FAIL reset_vld_fc: got %b want 1", c_fc_n); else pass_cnt++;
      c_vld = 1'b0;
   endtask

   task automatic test_first_write();
      do_reset();
      c_vld = 1'b1; c_data = 8'h3C;
      @(posedge clk); #1;
      chk_cnt++;
      if (p_srdy !== 1'b1) $display("FAIL first_srdy: got %b want 1", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (p_data !== 8'h3C) $display("FAIL first_data: got %h want 3c", p_data); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b1) $display("FAIL fc_usage1: got %b want 1", c_fc_n); else pass_cnt++;
      @(negedge clk);
      c_data = 8'h4D;
      @(posedge clk); #1;
      chk_cnt++;
      if (c_fc_n !== 1'b0) $display("FAIL fc_usage2: got %b want 0", c_fc_n); else pass_cnt++;
      chk_cnt++;
      if (p_data !== 8'h3C) $display("FAIL head_hold: got %h want 3c", p_data); else pass_cnt++;
      @(negedge clk);
      c_vld = 1'b0; p_drdy = 1'b1;
      @(posedge clk); #1;
      chk_cnt++;
      if (p_data !== 8'h4D || c_fc_n !== 1'b1)
         $display("FAIL pop_one: data %h fc %b want 4d 1", p_data, c_fc_n);
      else pass_cnt++;
      @(negedge clk);
      p_drdy = 1'b0;
   endtask

   task automatic test_full_drop();
      logic [W-1:0] expv;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         c_vld = 1'b1; c_data = 8'(8'h10 + i);
         @(negedge clk);
      end
      chk_cnt++;
      if (p_srdy !== 1'b1) $display("FAIL full_srdy: got %b want 1", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (p_data !== 8'h10) $display("FAIL full_head: got %h want 10", p_data); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b0) $display("FAIL full_fc: got %b want 0", c_fc_n); else pass_cnt++;
      c_vld = 1'b1; c_data = 8'hAA;
      @(negedge clk);
      chk_cnt++;
      if (p_data !== 8'h10) $display("FAIL drop_head: got %h want 10", p_data); else pass_cnt++;
      c_vld = 1'b1; c_data = 8'h18; p_drdy = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (p_data !== 8'h11) $display("FAIL full_rw_head: got %h want 11", p_data); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b0) $display("FAIL full_rw_fc: got %b want 0", c_fc_n); else pass_cnt++;
      c_vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         expv = 8'(8'h11 + i);
         chk_cnt++;
         if (p_srdy !== 1'b1 || p_data !== expv)
            $display("FAIL drain_%0d: srdy %b data %h want 1 %h", i, p_srdy, p_data, expv);
         else pass_cnt++;
         @(negedge clk);
      end
      chk_cnt++;
      if (p_srdy !== 1'b0) $display("FAIL drained_srdy: got %b want 0", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b1) $display("FAIL drained_fc: got %b want 1", c_fc_n); else pass_cnt++;
      @(negedge clk);
      c_vld = 1'b1; c_data = 8'h5E; p_drdy = 1'b0;
      @(negedge clk);
      c_vld = 1'b0;
      chk_cnt++;
      if (p_srdy !== 1'b1 || p_data !== 8'h5E)
         $display("FAIL after_empty_read: srdy %b data %h want 1 5e", p_srdy, p_data);
      else pass_cnt++;
   endtask

   task automatic test_continuous();
      do_reset();
      run_traffic(32'hFF, 8, 32'hFF, 8, 40, 0);
      chk_cnt++;
      if (ok_cnt !== 37) $display("FAIL cont_count: got %0d want 37", ok_cnt); else pass_cnt++;
      chk_cnt++;
      if (data_err !== 0) $display("FAIL cont_data: errors %0d want 0", data_err); else pass_cnt++;
      chk_cnt++;
      if (fc_low !== 0) $display("FAIL cont_fc_low: cycles %0d want 0", fc_low); else pass_cnt++;
      chk_cnt++;
      if (peak !== 1) $display("FAIL cont_peak: got %0d want 1", peak); else pass_cnt++;
      chk_cnt++;
      if (srdy_err !== 0) $display("FAIL cont_srdy: errors %0d want 0", srdy_err); else pass_cnt++;
      chk_cnt++;
      if (fc_err !== 0) $display("FAIL cont_fc: errors %0d want 0", fc_err); else pass_cnt++;
   endtask

   task automatic test_pattern();
      do_reset();
      run_traffic(32'h5A, 8, 32'hFF, 8, 100, 0);
      run_traffic(32'hFF, 8, 32'hA5, 8, 100, 0);
      chk_cnt++;
      if (data_err !== 0) $display("FAIL pat_data: errors %0d want 0", data_err); else pass_cnt++;
      chk_cnt++;
      if (srdy_err !== 0) $display("FAIL pat_srdy: errors %0d want 0", srdy_err); else pass_cnt++;
      chk_cnt++;
      if (fc_err !== 0) $display("FAIL pat_fc: errors %0d want 0", fc_err); else pass_cnt++;
      chk_cnt++;
      if (ok_cnt < 50) $display("FAIL pat_count: got %0d want >= 50", ok_cnt); else pass_cnt++;
   endtask

   task automatic test_overflow();
      do_reset();
      run_traffic(32'hFD, 8, 32'h03, 8, 300, 0);
      chk_cnt++;
      if (peak > D) $display("FAIL ovf_peak: got %0d want <= %0d", peak, D); else pass_cnt++;
      chk_cnt++;
      if (fc_err !== 0) $display("FAIL ovf_fc: errors %0d want 0", fc_err); else pass_cnt++;
      chk_cnt++;
      if (ovf_cnt !== 0) $display("FAIL ovf_wr_full: count %0d want 0", ovf_cnt); else pass_cnt++;
      chk_cnt++;
      if (data_err !== 0) $display("FAIL ovf_data: errors %0d want 0", data_err); else pass_cnt++;
      chk_cnt++;
      if (fc_low == 0) $display("FAIL ovf_fc_low: cycles %0d want > 0", fc_low); else pass_cnt++;
      chk_cnt++;
      if (srdy_err !== 0) $display("FAIL ovf_srdy: errors %0d want 0", srdy_err); else pass_cnt++;
   endtask

   task automatic test_underflow();
      do_reset();
      run_traffic(32'h11, 8, 32'hEE, 8, 200, 0);
      chk_cnt++;
      if (srdy_err !== 0) $display("FAIL udf_srdy: errors %0d want 0", srdy_err); else pass_cnt++;
      chk_cnt++;
      if (uflow_cnt !== 0) $display("FAIL udf_read_empty: count %0d want 0", uflow_cnt); else pass_cnt++;
      chk_cnt++;
      if (data_err !== 0) $display("FAIL udf_data: errors %0d want 0", data_err); else pass_cnt++;
      chk_cnt++;
      if (ok_cnt < 20) $display("FAIL udf_count: got %0d want >= 20", ok_cnt); else pass_cnt++;
   endtask

   task automatic test_runout();
      do_reset();
      run_traffic(32'hFFFF0000, 32, 32'h0000FFFF, 32, 10000, 1000);
      chk_cnt++;
      if (ok_cnt < 1000) $display("FAIL run_count: got %0d want >= 1000", ok_cnt); else pass_cnt++;
      chk_cnt++;
      if (data_err !== 0) $display("FAIL run_data: errors %0d want 0", data_err); else pass_cnt++;
      chk_cnt++;
      if (ovf_cnt !== 0 || fc_err !== 0)
         $display("FAIL run_link: ovf %0d fc_err %0d want 0 0", ovf_cnt, fc_err);
      else pass_cnt++;
   endtask

   task automatic test_reset_midop();
      logic [W-1:0] next_val;
      int guard;
      do_reset();
      src_pat = 32'hFF; src_len = 8; snk_pat = 32'h00; snk_len = 8;
      src_idx = 0; snk_idx = 0;
      guard = 0;
      while (m_usage != 4 && guard < 50) begin
         link_cycle();
         guard++;
      end
      chk_cnt++;
      if (p_srdy !== 1'b1 || m_usage != 4)
         $display("FAIL mid_fill: srdy %b usage %0d want 1 4", p_srdy, m_usage);
      else pass_cnt++;
      reset = 1'b0;
      c_vld = 1'b1; c_data = 8'hEE;
      #1;
      chk_cnt++;
      if (p_srdy !== 1'b0) $display("FAIL mid_srdy: got %b want 0", p_srdy); else pass_cnt++;
      chk_cnt++;
      if (c_fc_n !== 1'b1) $display("FAIL mid_fc: got %b want 1", c_fc_n); else pass_cnt++;
      repeat (2) @(negedge clk);
      clear_link();
      clear_stats();
      next_val = s_seq;
      exp_seq  = s_seq;
      reset = 1'b1;
      snk_pat = 32'hFF;
      for (int i = 0; i < 12; i++) link_cycle();
      chk_cnt++;
      if (first_seen !== 1'b1 || first_rd !== next_val)
         $display("FAIL mid_first: seen %b data %h want 1 %h", first_seen, first_rd, next_val);
      else pass_cnt++;
      chk_cnt++;
      if (data_err !== 0 || srdy_err !== 0)
         $display("FAIL mid_after: data_err %0d srdy_err %0d want 0 0", data_err, srdy_err);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_first_write();
      test_full_drop();
      test_continuous();
      test_pattern();
      test_overflow();
      test_underflow();
      test_runout();
      test_reset_midop();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d/%0d done", pass_cnt, chk_cnt);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dfc_rx_fifo.md
DFC_RX_FIFO -- requirements
Module: dfc_rx_fifo

Interface
REQ-001 Parameter width, default 8: data bits per word.
REQ-002 Parameter depth, default 8: FIFO entries; power of two, >= 2.
REQ-003 Parameter threshold, default 1: occupancy at or below which credit (c_fc_n=1) is granted.
REQ-004 Derived constant asz = clog2(depth); not user-settable.
REQ-005 One clock; reset is asynchronous and active-low. Ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 c_vld  input  1  word present on the link this cycle; no backpressure on the link side.
REQ-009 c_data  input  width  link data; valid when c_vld=1.
REQ-010 c_fc_n  output  1  flow control to the sender; 1 = may send, 0 = stop.
REQ-011 p_srdy  output  1  FIFO non-empty, p_data valid.
REQ-012 p_data  output  width  head-of-FIFO word.
REQ-013 p_drdy  input  1  consumer accepts; transfer occurs when p_srdy=1 and p_drdy=1.

Function
REQ-014 Write occurs on the rising edge when c_vld=1: c_data is stored at the write pointer, and the pointer advances.
REQ-015 Read occurs on the rising edge when p_srdy=1 and p_drdy=1: the read pointer advances.
REQ-016 Pointers are asz+1 bits and wrap naturally.
- empty = pointers equal.
- full = MSBs differ and low bits equal.
- usage = wr_ptr - rd_ptr, range 0..depth.
REQ-017 p_srdy = !empty and p_data = mem[rd_ptr low bits], both driven from registered state only; no combinational path from c_vld or p_drdy.
REQ-018 Latency: a word written at edge t is visible on p_srdy/p_data in the cycle after edge t.
REQ-019 Data leaves in strict arrival order; no loss, duplication or reordering while depth is not exceeded.
REQ-020 Simultaneous read and write, including when full or when the FIFO holds one entry, are both performed in the same cycle; usage is unchanged.
REQ-021 Write while full with no read is dropped: memory and wr_ptr are unchanged. This is a link protocol violation that the bench flags.
REQ-022 Read while empty is ignored.
REQ-023 c_fc_n is a register: c_fc_n <= (usage_next <= threshold), where usage_next is the occupancy after this edge's read and write.
REQ-024 The link round trip is up to 5 cycles: c_fc_n flop, 2 fc delay stages, sender register, 2 data stages. The sender may therefore deliver up to 5 words after c_fc_n falls.
REQ-025 Depth is sized so that depth >= threshold + 1 + 5. Defaults give 8 >= 7.
REQ-026 Elaboration fails if depth is not a power of two, or if threshold >= depth.

Reset
REQ-027 While reset=0:
- wr_ptr and rd_ptr = 0, so p_srdy=0.
- c_fc_n = 1.
- Memory contents are not reset; p_data is don't-care while p_srdy=0.
REQ-028 Reset asserted mid-operation discards all stored words immediately; c_vld is ignored while reset=0.
REQ-029 The first write is accepted on the first rising edge after reset deasserts.

Structure
REQ-030 Shared package dfc_pkg holds the round-trip slack constant (5) and the depth/threshold legality check used by REQ-025 and REQ-026.
REQ-031 Storage is one sub-module, dfc_rx_mem: depth x width, 1 write port, asynchronous read, no reset. Pointers, usage and flow control stay in dfc_rx_fifo.

Verification
REQ-032 Bench: a sequence generator feeds a credit sender. Its data and vld pass through 2 register stages into the DUT; c_fc_n returns through 2 stages. A sequence checker sits on the p_ side.
REQ-033 Scenarios:
- Reset, then continuous source and sink for 40 cycles -> incrementing bytes arrive in order; c_fc_n stays 1 with usage <= 1.
- Source srdy pattern 0x5A repeating, then sink drdy pattern 0xA5 -> no data error; p_srdy drops only when empty.
- Overflow stress, source 0xFD, sink 0x03 -> usage peaks <= 8, c_fc_n=0 whenever usage_next > 1, and no write-while-full occurs.
- Underflow stress, source 0x11, sink 0xEE -> p_srdy=0 whenever empty, and no read occurs while empty.
- Runout with source 0xFFFF0000 and sink 0x0000FFFF, for up to 10000 cycles -> checker ok count >= 1000 with zero mismatches.
- Reset asserted with usage = 4 -> p_srdy=0 and c_fc_n=1 immediately; after reset the next written value is the first one read.
